// File: rtl/scfifo.sv
// scfifo: single-clock first-word-fall-through FIFO.
// A DEPTH-entry RAM with a registered read port feeds a one-word prefetch
// register, which in turn feeds the registered output word. A word keeps its
// RAM slot until it is popped from the output. This means total capacity is
// exactly DEPTH, and the prefetch register lets a pop be followed by the next
// word without a bubble.
module scfifo #(
   parameter int unsigned ADDR_WIDTH    = 3,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                  aclk,
   input  logic                  srst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  full,
   output logic                  empty,
   output logic                  afull,
   output logic                  aempty
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned LW    = ADDR_WIDTH + 1;

   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THRESH);

   // Reject illegal parameter combinations at elaboration
   if (!(ADDR_WIDTH >= 1 && AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH
         && AFULL_THRESH <= DEPTH)) begin : g_bad_params
      $fatal(1, "scfifo: illegal ADDR_WIDTH/AEMPTY_THRESH/AFULL_THRESH combination");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         ram_cnt_q, ram_cnt_d;   // words written but not yet read out of the RAM
   logic [LW-1:0]         level_q, level_d;
   logic [DATA_WIDTH-1:0] ram_rd_q;               // prefetch register (RAM read port)
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;

   logic push_c, pop_c, load_out_c, rd_en_c, wr_en_c;

   // Handshakes, prefetch control and next-state computation
   always_comb begin
      push_c     = in_valid && in_ready_q;
      pop_c      = out_valid_q && out_ready;
      load_out_c = rd_valid_q && (!out_valid_q || pop_c);
      rd_en_c    = (ram_cnt_q != '0) && (!rd_valid_q || load_out_c) && !flush;
      wr_en_c    = push_c && !flush;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ram_cnt_d   = ram_cnt_q;
      level_d     = level_q;
      rd_valid_d  = rd_valid_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         ram_cnt_d   = '0;
         level_d     = '0;
         rd_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end else begin
         wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(push_c);
         rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(rd_en_c);
         ram_cnt_d   = ram_cnt_q + LW'(push_c) - LW'(rd_en_c);
         level_d     = level_q + LW'(push_c) - LW'(pop_c);
         rd_valid_d  = rd_en_c || (rd_valid_q && !load_out_c);
         out_valid_d = load_out_c || (out_valid_q && !pop_c);
         if (load_out_c) begin
            out_data_d = ram_rd_q;
         end
      end

      full_d     = (level_d == DEPTH_L);
      empty_d    = (level_d == '0);
      afull_d    = (level_d >= AFULL_L);
      aempty_d   = (level_d <= AEMPTY_L);
      in_ready_d = !full_d;
   end

   // Storage array write port (contents are not reset)
   always_ff @(posedge aclk) begin
      if (wr_en_c && !srst) begin
         mem[wr_ptr_q] <= in_data;
      end
   end

   // Registered RAM read port feeding the prefetch stage
   always_ff @(posedge aclk) begin
      if (srst) begin
         ram_rd_q <= '0;
      end else if (rd_en_c) begin
         ram_rd_q <= mem[rd_ptr_q];
      end
   end

   // Pointer, count, output and flag registers
   always_ff @(posedge aclk) begin
      if (srst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_cnt_q   <= '0;
         level_q     <= '0;
         rd_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b1;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_cnt_q   <= ram_cnt_d;
         level_q     <= level_d;
         rd_valid_q  <= rd_valid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign level     = level_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign afull     = afull_q;
   assign aempty    = aempty_q;

endmodule

// File: tb/tb_scfifo.sv
// tb_scfifo: directed self-checking bench for scfifo (DEPTH=8, 8-bit, thresholds 6/2).
module tb_scfifo;

   logic       aclk;
   logic       srst;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] level;
   logic       full, empty, afull, aempty;

   int n_tests = 0;
   int n_fail  = 0;

   scfifo #(
      .ADDR_WIDTH   (3),
      .DATA_WIDTH   (8),
      .AFULL_THRESH (6),
      .AEMPTY_THRESH(2)
   ) dut (
      .aclk     (aclk),
      .srst     (srst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .level    (level),
      .full     (full),
      .empty    (empty),
      .afull    (afull),
      .aempty   (aempty)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge; outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " level"},     32'(level),     32'd0);
      check({tag, " empty"},     32'(empty),     32'd1);
      check({tag, " aempty"},    32'(aempty),    32'd1);
      check({tag, " full"},      32'(full),      32'd0);
      check({tag, " afull"},     32'(afull),     32'd0);
      check({tag, " in_ready"},  32'(in_ready),  32'd1);
      check({tag, " out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " out_data"},  32'(out_data),  32'd0);
   endtask

   initial begin
      srst      = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      tick();
      tick();
      check_reset_state("reset");
      srst = 1'b0;

      // Single word latency: visible two edges after the push
      in_valid = 1'b1;
      in_data  = 8'h11;
      tick();
      in_valid = 1'b0;
      check("lat level k",     32'(level),     32'd1);
      check("lat empty k",     32'(empty),     32'd0);
      check("lat out_valid k", 32'(out_valid), 32'd0);
      tick();
      check("lat out_valid k+1", 32'(out_valid), 32'd0);
      tick();
      check("lat out_valid k+2", 32'(out_valid), 32'd1);
      check("lat out_data k+2",  32'(out_data),  32'h11);
      tick();
      check("lat hold valid", 32'(out_valid), 32'd1);
      check("lat hold data",  32'(out_data),  32'h11);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("lat pop out_valid", 32'(out_valid), 32'd0);
      check("lat pop empty",     32'(empty),     32'd1);

      // Fill to full, then an ignored ninth push
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         tick();
         check($sformatf("fill level %0d", i), 32'(level),  32'(i + 1));
         check($sformatf("fill afull %0d", i), 32'(afull),  32'(i + 1 >= 6));
         check($sformatf("fill aempty %0d", i), 32'(aempty), 32'(i + 1 <= 2));
      end
      check("fill full",     32'(full),     32'd1);
      check("fill in_ready", 32'(in_ready), 32'd0);
      in_data = 8'hFF;
      tick();
      in_valid = 1'b0;
      check("ninth push level", 32'(level), 32'd8);
      check("ninth push full",  32'(full),  32'd1);

      // Drain from full with no bubble
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain valid %0d", i), 32'(out_valid), 32'd1);
         check($sformatf("drain data %0d", i),  32'(out_data),  32'(i));
         tick();
         check($sformatf("drain level %0d", i), 32'(level), 32'(7 - i));
      end
      out_ready = 1'b0;
      check("drain out_valid end", 32'(out_valid), 32'd0);
      check("drain empty end",     32'(empty),     32'd1);
      check("drain in_ready end",  32'(in_ready),  32'd1);

      // Steady push+pop at level 4 across 20 words
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h20 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1'b1;
         in_data   = 8'h24 + 8'(i);
         out_ready = 1'b1;
         check($sformatf("stream valid %0d", i), 32'(out_valid), 32'd1);
         check($sformatf("stream data %0d", i),  32'(out_data),  32'h20 + 32'(i));
         tick();
         check($sformatf("stream level %0d", i), 32'(level), 32'd4);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("stream tail data %0d", i), 32'(out_data), 32'h34 + 32'(i));
         tick();
      end
      out_ready = 1'b0;
      check("stream empty", 32'(empty), 32'd1);

      // Flush at level 5 with a simultaneous push that must be discarded
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h40 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("pre-flush level", 32'(level), 32'd5);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush level",     32'(level),     32'd0);
      check("flush out_valid", 32'(out_valid), 32'd0);
      check("flush empty",     32'(empty),     32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post-flush idle %0d", i), 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("post-flush word valid", 32'(out_valid), 32'd1);
      check("post-flush word data",  32'(out_data),  32'h55);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post-flush drained", 32'(out_valid), 32'd0);

      // Reset mid-operation at level 3, then immediate push
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h60 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("pre-srst out_valid", 32'(out_valid), 32'd1);
      check("pre-srst level",     32'(level),     32'd3);
      srst  = 1'b1;
      flush = 1'b1;
      tick();
      srst  = 1'b0;
      flush = 1'b0;
      check_reset_state("midrst");
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();
      in_valid = 1'b0;
      check("post-srst level", 32'(level), 32'd1);
      tick();
      tick();
      check("post-srst valid", 32'(out_valid), 32'd1);
      check("post-srst data",  32'(out_data),  32'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
